// File: rtl/audio_playback.sv
// audio_playback: Avalon-MM playback peripheral. Software pushes 24-bit
// samples into a circular FIFO; each codec advance pulse pops one sample
// onto both DAC channels. Includes prime threshold, underrun/overflow
// accounting and a low-watermark interrupt.
module audio_playback #(
    parameter int RAM_ADDR_BITS = 11,
    parameter int RAM_WORDS     = 2048,
    parameter int RAM_WIDTH     = 24,
    parameter int PRIME_DEFAULT = 256,
    parameter int LOW_WATER     = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 write,
    input  logic                 read,
    input  logic [15:0]          address,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic                 advance,
    output logic [RAM_WIDTH-1:0] dac_left,
    output logic [RAM_WIDTH-1:0] dac_right,
    output logic                 irq
);

    localparam int FILL_W = RAM_ADDR_BITS + 1;
    localparam logic [FILL_W-1:0] DEPTH = FILL_W'(RAM_WORDS);
    localparam logic [FILL_W-1:0] LOW   = FILL_W'(LOW_WATER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    logic [RAM_WIDTH-1:0]     r_mem [RAM_WORDS];
    logic [RAM_ADDR_BITS-1:0] r_wr_ptr;
    logic [RAM_ADDR_BITS-1:0] r_rd_ptr;
    logic [FILL_W-1:0]        r_fill;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_irq_en;
    logic [15:0]              r_thresh;
    logic                     r_overflow;
    logic                     r_underrun;
    logic [15:0]              r_urun_cnt;
    logic [RAM_WIDTH-1:0]     r_dac;
    logic [31:0]              r_rdata;
    logic                     r_irq;

    logic        w_wr, w_rd;
    logic        w_push, w_ctrl_wr, w_urun_wr, w_thresh_wr, w_status_rd;
    logic        w_play, w_stop;
    logic        w_full, w_empty;
    logic        w_push_ok, w_ovf_evt;
    logic        w_pop_evt, w_pop_ok, w_urun_evt;
    logic [15:0] w_fill16;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr        = chipselect & write;
    assign w_rd        = chipselect & read;
    assign w_push      = w_wr & (address == 16'h0000);
    assign w_ctrl_wr   = w_wr & (address == 16'h0001);
    assign w_urun_wr   = w_wr & (address == 16'h0003);
    assign w_thresh_wr = w_wr & (address == 16'h0004);
    assign w_status_rd = w_rd & (address == 16'h0002);
    assign w_stop      = w_ctrl_wr & writedata[1];
    assign w_play      = w_ctrl_wr & writedata[0] & ~writedata[1];

    assign w_full     = (r_fill == DEPTH);
    assign w_empty    = (r_fill == '0);
    assign w_fill16   = 16'(r_fill);
    // Full is judged on the fill at the start of the cycle, so a concurrent pop never rescues a push
    assign w_push_ok  = w_push & ~w_full;
    assign w_ovf_evt  = w_push & w_full;
    assign w_pop_evt  = (r_state == S_PLAY) & advance & ~w_stop;
    assign w_pop_ok   = w_pop_evt & ~w_empty;
    assign w_urun_evt = w_pop_evt & w_empty;

    assign w_unused   = &{1'b0, writedata[31:24]};

    // Next-state logic: STOP overrides everything, PLAY only starts from IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_play) w_state_nxt = S_PRIME;
                S_PRIME: if (w_fill16 >= r_thresh) w_state_nxt = S_PLAY;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FIFO storage, written without reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= writedata[RAM_WIDTH-1:0];
    end

    // Pointers and fill level; STOP flushes the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (w_stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok & ~w_pop_ok)      r_fill <= r_fill + FILL_W'(1);
            else if (~w_push_ok & w_pop_ok) r_fill <= r_fill - FILL_W'(1);
        end
    end

    // DAC sample register: zero outside PLAY and on underrun, else holds between pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      r_dac <= '0;
        else if (w_stop)                r_dac <= '0;
        else if (r_state != S_PLAY)     r_dac <= '0;
        else if (w_pop_ok)              r_dac <= r_mem[r_rd_ptr];
        else if (w_urun_evt)            r_dac <= '0;
    end

    // Control/config registers and error accounting; set beats STATUS-read clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en   <= 1'b0;
            r_thresh   <= 16'(PRIME_DEFAULT);
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
            r_urun_cnt <= '0;
        end else begin
            if (w_ctrl_wr)   r_irq_en <= writedata[2];
            if (w_thresh_wr) r_thresh <= writedata[15:0];
            if (w_ovf_evt)        r_overflow <= 1'b1;
            else if (w_status_rd) r_overflow <= 1'b0;
            if (w_urun_evt)       r_underrun <= 1'b1;
            else if (w_status_rd) r_underrun <= 1'b0;
            if (w_urun_wr)                                r_urun_cnt <= '0;
            else if (w_urun_evt && r_urun_cnt != 16'hFFFF) r_urun_cnt <= r_urun_cnt + 16'd1;
        end
    end

    // Read-data mux for the register map
    always_comb begin
        w_rdata = '0;
        case (address)
            16'h0001: w_rdata = {29'b0, r_irq_en, 2'b0};
            16'h0002: w_rdata = {10'b0, r_state, r_underrun, r_overflow, w_full, w_empty, w_fill16};
            16'h0003: w_rdata = {16'b0, r_urun_cnt};
            16'h0004: w_rdata = {16'b0, r_thresh};
            default:  w_rdata = '0;
        endcase
    end

    // Registered read data and low-watermark interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rdata;
            r_irq <= r_irq_en && (r_state == S_PLAY) && (r_fill < LOW);
        end
    end

    assign readdata  = r_rdata;
    assign dac_left  = r_dac;
    assign dac_right = r_dac;
    assign irq       = r_irq;

endmodule

// File: doc/audio_playback.md
Name: audio_playback

Overview:
- Avalon-MM playback peripheral; the output-direction counterpart of the ADC capture path.
- Software pushes 24-bit signed samples with iowrite into a circular BRAM FIFO.
- On each codec `advance` pulse the block pops one sample and drives it, mono, onto the audio driver's dac_left/dac_right inputs.
- Provides prime threshold, underrun/overflow accounting and a low-watermark interrupt.

Parameters:
- RAM_ADDR_BITS, 11, FIFO address width.
- RAM_WORDS, 2048, FIFO depth; must equal 2**RAM_ADDR_BITS.
- RAM_WIDTH, 24, sample width.
- PRIME_DEFAULT, 256, reset value of THRESH.
- LOW_WATER, 512, irq asserts when fill is below this.

Ports:
- clk  in  1  system clock (50 MHz); the only clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  16  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- advance  in  1  one-cycle pulse from audio_driver: DAC consumed the current sample.
- dac_left  out  24  sample to audio_driver left channel.
- dac_right  out  24  identical to dac_left.
- irq  out  1  low-watermark interrupt, level, registered.

Behaviour:
- Reset (async, high): pointers=0, fill=0, state=IDLE, dac_left/dac_right=0, readdata=0, irq=0, ctrl=0, THRESH=PRIME_DEFAULT, sticky flags=0, underrun count=0.
- Register map, decoded when chipselect=1:
  - 0x0 SAMPLE W: push writedata[23:0]; bits 31:24 ignored.
  - 0x1 CTRL W: bit0 PLAY, bit1 STOP, bit2 IRQ_EN. R: {29'b0, IRQ_EN, 2'b0}.
  - 0x2 STATUS R: [15:0] fill, [16] empty, [17] full, [18] overflow, [19] underrun, [21:20] state (0 IDLE, 1 PRIME, 2 PLAY), rest 0.
  - 0x3 UNDERRUNS R: 16-bit count, zero-extended. Any write clears the count.
  - 0x4 THRESH R/W: [15:0].
  - Unmapped reads return 0; unmapped writes are ignored.
- readdata is valid the cycle after the chipselect&read cycle; it holds otherwise.
- Push:
  - Accepted when fill<RAM_WORDS at the start of the cycle.
  - On accept: mem[wr_ptr]<=sample, wr_ptr wraps modulo RAM_WORDS.
  - When full: sample dropped, overflow sticky set. A pop in the same cycle does not rescue it.
  - Pushes are accepted in every state.
- Pop occurs only in PLAY on advance=1:
  - Non-empty: dac_left/dac_right <= mem[rd_ptr] exactly 1 cycle after the advance cycle; rd_ptr wraps.
  - Empty: dac outputs <= 0, underrun sticky set, count +1 saturating at 16'hFFFF. The block stays in PLAY.
  - A sample is eligible if its push cycle preceded the advance cycle.
  - Simultaneous push and pop: both take effect; fill unchanged.
- State machine:
  - IDLE: dac outputs=0, advance ignored. PLAY write -> PRIME.
  - PRIME: dac outputs=0, no pops. -> PLAY on the first cycle fill>=THRESH; THRESH=0 means the next cycle.
  - PLAY: pops as above.
  - STOP write (any state): -> IDLE next cycle; wr_ptr=rd_ptr=fill=0; dac outputs=0; sticky flags and THRESH retained.
  - PLAY and STOP set in the same write: STOP wins.
  - PLAY write while already in PRIME or PLAY: no effect.
- STATUS read clears overflow/underrun stickies after capture. If a set event occurs in the same cycle, set wins.
- irq = IRQ_EN && state==PLAY && fill<LOW_WATER, registered (1-cycle lag).
- dac outputs hold their value between updates.

Test Plan:
- Reset mid-PLAY with fill=100 -> next cycle: state=0, fill=0, dac=0, irq=0, THRESH=256.
- Push 0x000001, 0x7FFFFF, 0x800000; THRESH=3; PLAY; three advances -> dac sequence 0x000001, 0x7FFFFF, 0x800000, each 1 cycle after its advance; a 4th advance -> dac=0, UNDERRUNS=1, STATUS[19]=1.
- Push 2049 samples in IDLE -> fill=2048, full=1, overflow=1. Read STATUS twice -> second read shows overflow=0. The 2049th sample is never played.
- Wrap: push and pop 3000 samples with a counter pattern while keeping fill<2048 -> dac output matches the pattern with no gaps across pointer wrap.
- THRESH=10; push 9 -> state stays PRIME and advances produce no pops; push 1 more -> PLAY one cycle later.
- IRQ_EN=1, PLAY with fill=600; advance 89 times -> fill=511, irq rises one cycle later. STOP -> irq=0, fill=0.
